rf_wb_arbiter: RTL and testbench

Writeback arbiter that drives the integer register file's single write port (wen/waddr/wdata) from two independent result producers: the execute unit (EXU) and the load/store unit (LSU). Each producer hands results over with a valid/ready handshake into its own 2-entry FIFO. A round-robin arbiter drains one result per cycle through a registered output stage. The block also exports a pending-write scoreboard for hazard detection in decode.

---
 rtl/rf_wb_arbiter_if.sv | 31 +++
 rtl/rf_wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: two producer handshakes, the register-file write
// port and the pending-write scoreboard.
interface rf_wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            exu_valid;
    logic            exu_ready;
    logic [4:0]      exu_rd;
    logic [XLEN-1:0] exu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            wen;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic [31:0]     busy;
    logic [63:0]     wb_count;

    // Producer side (execute / load-store units) and register-file observer.
    modport master (
        output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
        input  exu_ready, lsu_ready, wen, waddr, wdata, busy, wb_count
    );

    // Arbiter side.
    modport slave (
        input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
        output exu_ready, lsu_ready, wen, waddr, wdata, busy, wb_count
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: EXU and LSU results each queue in a small FIFO; a
// round-robin grant drains one result per cycle into a registered
// register-file write port. Also exports a pending-write scoreboard.
// Source index 0 is the EXU, index 1 is the LSU. DEPTH must be a power of
// two and at least 2.
module rf_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic           i_clk,
    input  logic           i_reset,
    rf_wb_arbiter_if.slave wb_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic            w_in_valid [2];
    logic [4:0]      w_in_rd    [2];
    logic [XLEN-1:0] w_in_data  [2];

    logic [4:0]      r_rd   [2][DEPTH];
    logic [XLEN-1:0] r_data [2][DEPTH];
    logic [PW-1:0]   r_wp   [2];
    logic [PW-1:0]   r_rp   [2];

    logic [PW-1:0]   w_cnt   [2];
    logic            w_empty [2];
    logic            w_full  [2];
    logic            w_ready [2];
    logic            w_push  [2];

    logic            r_last;      // source granted most recently (1 = LSU)
    logic            w_gnt_v;
    logic            w_gnt_sel;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;

    logic            r_wen;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic [63:0]     r_wb_count;
    logic [31:0]     w_busy;

    assign w_in_valid[0] = wb_if.exu_valid;
    assign w_in_rd[0]    = wb_if.exu_rd;
    assign w_in_data[0]  = wb_if.exu_data;
    assign w_in_valid[1] = wb_if.lsu_valid;
    assign w_in_rd[1]    = wb_if.lsu_rd;
    assign w_in_data[1]  = wb_if.lsu_data;

    // FIFO occupancy flags; ready depends only on state and reset, never on valid or pop.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_cnt[s]   = r_wp[s] - r_rp[s];
            w_empty[s] = (r_wp[s] == r_rp[s]);
            w_full[s]  = ((r_wp[s] ^ r_rp[s]) == {1'b1, {AW{1'b0}}});
            w_ready[s] = !i_reset && !w_full[s];
            // x0 results complete the handshake but are never stored.
            w_push[s]  = w_in_valid[s] && w_ready[s] && (w_in_rd[s] != 5'd0);
        end
    end

    // Round-robin grant over the two FIFO heads; on a tie the source not granted last wins.
    always_comb begin
        w_gnt_v   = 1'b0;
        w_gnt_sel = 1'b0;
        if (!w_empty[0] && !w_empty[1]) begin
            w_gnt_v   = 1'b1;
            w_gnt_sel = ~r_last;
        end else if (!w_empty[0]) begin
            w_gnt_v   = 1'b1;
            w_gnt_sel = 1'b0;
        end else if (!w_empty[1]) begin
            w_gnt_v   = 1'b1;
            w_gnt_sel = 1'b1;
        end else begin
            w_gnt_v   = 1'b0;
            w_gnt_sel = 1'b0;
        end
        w_head_rd   = r_rd[w_gnt_sel][r_rp[w_gnt_sel][AW-1:0]];
        w_head_data = r_data[w_gnt_sel][r_rp[w_gnt_sel][AW-1:0]];
    end

    // Scoreboard: every queued destination plus the one in the output stage.
    always_comb begin
        w_busy = 32'd0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (PW'(k) < w_cnt[s]) begin
                    w_busy = w_busy | (32'd1 << r_rd[s][AW'(r_rp[s][AW-1:0] + AW'(k))]);
                end else begin
                    w_busy = w_busy;
                end
            end
        end
        if (r_wen) begin
            w_busy = w_busy | (32'd1 << r_waddr);
        end else begin
            w_busy = w_busy;
        end
        w_busy[0] = 1'b0;
    end

    // FIFO storage/pointers, grant history and the registered write port.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < 2; s++) begin
                r_wp[s] <= {PW{1'b0}};
                r_rp[s] <= {PW{1'b0}};
                for (int i = 0; i < DEPTH; i++) begin
                    r_rd[s][i]   <= 5'd0;
                    r_data[s][i] <= {XLEN{1'b0}};
                end
            end
            r_last     <= 1'b1;
            r_wen      <= 1'b0;
            r_waddr    <= 5'd0;
            r_wdata    <= {XLEN{1'b0}};
            r_wb_count <= 64'd0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_rd[s][r_wp[s][AW-1:0]]   <= w_in_rd[s];
                    r_data[s][r_wp[s][AW-1:0]] <= w_in_data[s];
                    r_wp[s]                    <= r_wp[s] + PW'(1);
                end
                if (w_gnt_v && (w_gnt_sel == 1'(s))) begin
                    r_rp[s] <= r_rp[s] + PW'(1);
                end
            end
            if (w_gnt_v) begin
                r_last     <= w_gnt_sel;
                r_wen      <= 1'b1;
                r_waddr    <= w_head_rd;
                r_wdata    <= w_head_data;
                r_wb_count <= r_wb_count + 64'd1;
            end else begin
                r_wen      <= 1'b0;
            end
        end
    end

    assign wb_if.exu_ready = w_ready[0];
    assign wb_if.lsu_ready = w_ready[1];
    assign wb_if.wen       = r_wen;
    assign wb_if.waddr     = r_waddr;
    assign wb_if.wdata     = r_wdata;
    assign wb_if.busy      = w_busy;
    assign wb_if.wb_count  = r_wb_count;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: a table of per-cycle vectors with hand-computed
// outputs, then streamed contention and FIFO wrap-around sequences.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] exp_cnt = 64'd0;

    rf_wb_arbiter_if #(.XLEN(64)) bus ();

    rf_wb_arbiter #(.DEPTH(2), .XLEN(64)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .wb_if   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ev;
        logic [4:0]  erd;
        logic [63:0] ed;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ld;
        logic        xer;
        logic        xlr;
        logic        xwen;
        logic [4:0]  xwa;
        logic [63:0] xwd;
        logic [31:0] xbusy;
        logic [63:0] xcnt;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic logic [31:0] bb(input int n);
        return 32'd1 << n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.exu_valid = 1'b0; bus.exu_rd = 5'd0; bus.exu_data = 64'd0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 64'd0;
    endtask

    // Stream ne EXU and nl LSU results with full handshakes; expected write
    // order starts with EXU and alternates while both sources have work.
    task automatic run_stream(input int ne, input int nl, input string tag);
        logic [4:0]  q_rd [$];
        logic [63:0] q_d  [$];
        int ie = 0, il = 0, nw = 0, first_w = -1, last_w = -1;
        logic re, rl;
        for (int i = 0; i < ne || i < nl; i++) begin
            if (i < ne) begin q_rd.push_back(5'(1 + i));  q_d.push_back(64'hE000 + 64'(i)); end
            if (i < nl) begin q_rd.push_back(5'(17 + i)); q_d.push_back(64'hA000 + 64'(i)); end
        end
        for (int cyc = 0; cyc < 60 && nw < ne + nl; cyc++) begin
            bus.exu_valid = (ie < ne); bus.exu_rd = 5'(1 + ie);  bus.exu_data = 64'hE000 + 64'(ie);
            bus.lsu_valid = (il < nl); bus.lsu_rd = 5'(17 + il); bus.lsu_data = 64'hA000 + 64'(il);
            re = bus.exu_ready;
            rl = bus.lsu_ready;
            @(posedge clk); #1;
            if (bus.exu_valid && re) ie++;
            if (bus.lsu_valid && rl) il++;
            if (bus.wen) begin
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
                exp_cnt = exp_cnt + 64'd1;
                chk($sformatf("%s_w%0d_waddr", tag, nw), 64'(bus.waddr), 64'(q_rd[nw]));
                chk($sformatf("%s_w%0d_wdata", tag, nw), bus.wdata, q_d[nw]);
                chk($sformatf("%s_w%0d_wb_count", tag, nw), bus.wb_count, exp_cnt);
                nw++;
            end
        end
        idle_inputs();
        chk($sformatf("%s_writes", tag), 64'(nw), 64'(ne + nl));
        chk($sformatf("%s_back_to_back", tag), 64'(last_w - first_w + 1), 64'(ne + nl));
    endtask

    initial begin
        idle_inputs();
        //            rst   ev    erd    ed          lv    lrd     ld          er    lr    wen   wa      wd          busy                                  cnt
        vecs[0]  = '{1'b1, 1'b0, 5'd0, 64'h0,     1'b0, 5'd0,  64'h0,     1'b0, 1'b0, 1'b0, 5'd0,  64'h0,     32'd0,                                64'd0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5, 64'h1234,  1'b0, 5'd0,  64'h0,     1'b1, 1'b1, 1'b0, 5'd0,  64'h0,     bb(5),                                64'd0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 5'd5,  64'h1234,  bb(5),                                64'd1};
        vecs[3]  = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 5'd0,  64'h0,     1'b1, 1'b1, 1'b0, 5'd5,  64'h1234,  32'd0,                                64'd1};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b1, 5'd0,  64'hdead,  1'b1, 1'b1, 1'b0, 5'd5,  64'h1234,  32'd0,                                64'd1};
        vecs[5]  = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 5'd0,  64'h0,     1'b1, 1'b1, 1'b0, 5'd5,  64'h1234,  32'd0,                                64'd1};
        vecs[6]  = '{1'b0, 1'b1, 5'd1, 64'h11,    1'b1, 5'd17, 64'h71,    1'b1, 1'b1, 1'b0, 5'd5,  64'h1234,  bb(1) | bb(17),                       64'd1};
        vecs[7]  = '{1'b0, 1'b1, 5'd2, 64'h12,    1'b1, 5'd18, 64'h72,    1'b0, 1'b1, 1'b1, 5'd17, 64'h71,    bb(1) | bb(2) | bb(17) | bb(18),      64'd2};
        vecs[8]  = '{1'b0, 1'b1, 5'd3, 64'h13,    1'b1, 5'd19, 64'h73,    1'b1, 1'b0, 1'b1, 5'd1,  64'h11,    bb(1) | bb(2) | bb(18) | bb(19),      64'd3};
        vecs[9]  = '{1'b0, 1'b1, 5'd3, 64'h13,    1'b1, 5'd20, 64'h74,    1'b0, 1'b1, 1'b1, 5'd18, 64'h72,    bb(2) | bb(3) | bb(18) | bb(19),      64'd4};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b1, 5'd20, 64'h74,    1'b1, 1'b0, 1'b1, 5'd2,  64'h12,    bb(2) | bb(3) | bb(19) | bb(20),      64'd5};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 5'd19, 64'h73,    bb(3) | bb(19) | bb(20),              64'd6};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 5'd3,  64'h13,    bb(3) | bb(20),                       64'd7};
        vecs[13] = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 5'd20, 64'h74,    bb(20),                               64'd8};
        vecs[14] = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 5'd0,  64'h0,     1'b1, 1'b1, 1'b0, 5'd20, 64'h74,    32'd0,                                64'd8};
        vecs[15] = '{1'b0, 1'b1, 5'd6, 64'ha6,    1'b1, 5'd22, 64'hb6,    1'b1, 1'b1, 1'b0, 5'd20, 64'h74,    bb(6) | bb(22),                       64'd8};
        vecs[16] = '{1'b0, 1'b1, 5'd7, 64'ha7,    1'b1, 5'd23, 64'hb7,    1'b1, 1'b0, 1'b1, 5'd6,  64'ha6,    bb(6) | bb(7) | bb(22) | bb(23),      64'd9};
        vecs[17] = '{1'b0, 1'b1, 5'd8, 64'ha8,    1'b1, 5'd24, 64'hb8,    1'b0, 1'b1, 1'b1, 5'd22, 64'hb6,    bb(7) | bb(8) | bb(22) | bb(23),      64'd10};
        vecs[18] = '{1'b1, 1'b1, 5'd8, 64'ha8,    1'b1, 5'd24, 64'hb8,    1'b0, 1'b0, 1'b0, 5'd0,  64'h0,     32'd0,                                64'd0};
        vecs[19] = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 5'd0,  64'h0,     1'b1, 1'b1, 1'b0, 5'd0,  64'h0,     32'd0,                                64'd0};
        vecs[20] = '{1'b0, 1'b0, 5'd0, 64'h0,     1'b0, 5'd0,  64'h0,     1'b1, 1'b1, 1'b0, 5'd0,  64'h0,     32'd0,                                64'd0};

        for (int i = 0; i < NV; i++) begin
            reset         = vecs[i].rst;
            bus.exu_valid = vecs[i].ev;
            bus.exu_rd    = vecs[i].erd;
            bus.exu_data  = vecs[i].ed;
            bus.lsu_valid = vecs[i].lv;
            bus.lsu_rd    = vecs[i].lrd;
            bus.lsu_data  = vecs[i].ld;
            @(posedge clk); #1;
            chk($sformatf("v%0d_exu_ready", i), 64'(bus.exu_ready), 64'(vecs[i].xer));
            chk($sformatf("v%0d_lsu_ready", i), 64'(bus.lsu_ready), 64'(vecs[i].xlr));
            chk($sformatf("v%0d_wen", i),       64'(bus.wen),       64'(vecs[i].xwen));
            chk($sformatf("v%0d_waddr", i),     64'(bus.waddr),     64'(vecs[i].xwa));
            chk($sformatf("v%0d_wdata", i),     bus.wdata,          vecs[i].xwd);
            chk($sformatf("v%0d_busy", i),      64'(bus.busy),      64'(vecs[i].xbusy));
            chk($sformatf("v%0d_wb_count", i),  bus.wb_count,       vecs[i].xcnt);
        end

        exp_cnt = 64'd0;
        run_stream(8, 8, "contend");
        run_stream(0, 10, "wrap");

        @(posedge clk); #1;
        chk("final_wen", 64'(bus.wen), 64'd0);
        chk("final_busy", 64'(bus.busy), 64'd0);
        chk("final_wb_count", bus.wb_count, 64'd26);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
